// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults, arbitration mode enum and index helper for rr_arb_mux
package mux_pkg;

    localparam int DATA_W = 64;
    localparam int NCH    = 4;

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_t;

    // Folds an index taken from the doubled request vector back into 0..n-1.
    function automatic int wrap_idx(input int pos, input int n);
        return (pos >= n) ? pos - n : pos;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker over a doubled request vector
module rr_pick
    import mux_pkg::*;
#(
    parameter int N    = NCH,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] start,
    input  logic            fixed,
    output logic            any,
    output logic [SELW-1:0] idx
);

    logic [2*N-1:0]  req2;
    logic [N-1:0]    rot;
    logic [SELW-1:0] base;

    always_comb begin
        req2 = {req, req};
        base = fixed ? '0 : start;
        rot  = req2[base +: N];
        any  = |req;
        idx  = '0;
        // Walk downward so the request nearest to base is the one left in idx.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = SELW'(wrap_idx(int'(base) + k, N));
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel arbitrated mux with registered valid/ready output stage
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int N         = NCH,
    parameter int PRIO_MODE = int'(PRIO_RR),
    parameter int SELW      = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  last_q,      last_d;

    logic [SELW-1:0]  start;
    logic [SELW-1:0]  win;
    logic             any;
    logic             can_load;
    logic             grant;
    logic             fixed_mode;

    assign fixed_mode = (PRIO_MODE == int'(PRIO_FIXED));

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req   (in_valid),
        .start (start),
        .fixed (fixed_mode),
        .any   (any),
        .idx   (win)
    );

    always_comb begin
        start       = (last_q == SELW'(N - 1)) ? '0 : last_q + SELW'(1);
        can_load    = !out_valid_q || out_ready;
        // Reset suppresses the handshake so a word offered during reset is not lost.
        grant       = !reset && can_load && any;
        in_ready    = grant ? (N'(1) << win) : '0;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (can_load) begin
            out_valid_d = any;
            if (any) begin
                out_data_d = in_data[win*WIDTH +: WIDTH];
                out_sel_d  = win;
                last_d     = win;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            last_q      <= SELW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - directed scoreboard bench for rr_arb_mux (round-robin and fixed-priority)
module tb_rr_arb_mux;

    logic clk;

    logic          a_reset;
    logic [3:0]    a_in_valid;
    logic [255:0]  a_in_data;
    logic [3:0]    a_in_ready;
    logic          a_out_valid;
    logic [63:0]   a_out_data;
    logic [1:0]    a_out_sel;
    logic          a_out_ready;

    logic          b_reset;
    logic [2:0]    b_in_valid;
    logic [23:0]   b_in_data;
    logic [2:0]    b_in_ready;
    logic          b_out_valid;
    logic [7:0]    b_out_data;
    logic [1:0]    b_out_sel;
    logic          b_out_ready;

    rr_arb_mux #(.WIDTH(64), .N(4), .PRIO_MODE(0)) dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel),
        .out_ready (a_out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .N(3), .PRIO_MODE(1)) dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_ready (b_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          sel;
        logic [63:0] data;
    } sb_t;

    sb_t  sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    bit          m_valid = 1'b0;
    int          m_sel   = 0;
    logic [63:0] m_data  = '0;
    int          m_last  = 3;

    function automatic logic [63:0] chan_a(input int i);
        return 64'h1111_0000_0000_0000 * (i + 1);
    endfunction

    function automatic logic [7:0] chan_b(input int i);
        return 8'hA0 + 8'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic [3:0] v, input logic rdy, input logic rst, output int win);
        logic [3:0] exp_rdy;
        bit         can_load;
        sb_t        e;
        a_in_valid  = v;
        a_out_ready = rdy;
        a_reset     = rst;
        #1;
        can_load = !m_valid || rdy;
        win = -1;
        if (!rst && can_load) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_last + k) % 4;
                if (win < 0 && v[i]) win = i;
            end
        end
        exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0;
        chk("a_in_ready", 64'(a_in_ready), 64'(exp_rdy));
        if (win >= 0) begin
            e.sel  = win;
            e.data = chan_a(win);
            sb.push_back(e);
        end
        if (rst) begin
            m_valid = 1'b0;
            m_sel   = 0;
            m_data  = '0;
            m_last  = 3;
        end else if (can_load) begin
            m_valid = (win >= 0);
            if (win >= 0) m_last = win;
        end
        @(posedge clk);
        @(negedge clk);
        chk("a_out_valid", 64'(a_out_valid), 64'(m_valid));
        if (a_out_valid && sb.size() != 0) begin
            e      = sb.pop_front();
            m_sel  = e.sel;
            m_data = e.data;
        end
        chk("a_out_sel", 64'(a_out_sel), 64'(m_sel));
        chk("a_out_data", a_out_data, m_data);
    endtask

    task automatic step_b(input logic [2:0] v, input logic rst, output int win);
        logic [2:0] exp_rdy;
        b_in_valid  = v;
        b_out_ready = 1'b1;
        b_reset     = rst;
        #1;
        win = -1;
        if (!rst) begin
            for (int i = 0; i < 3; i++) if (win < 0 && v[i]) win = i;
        end
        exp_rdy = (win >= 0) ? 3'(1 << win) : 3'b0;
        chk("b_in_ready", 64'(b_in_ready), 64'(exp_rdy));
        @(posedge clk);
        @(negedge clk);
        chk("b_out_valid", 64'(b_out_valid), 64'(win >= 0));
        if (win >= 0) begin
            chk("b_out_sel", 64'(b_out_sel), 64'(win));
            chk("b_out_data", 64'(b_out_data), 64'(chan_b(win)));
        end
        chk("b_sel_range", 64'(b_out_sel < 2'd3), 64'(1));
    endtask

    initial begin
        int w;
        int rot_exp[5];
        rot_exp = '{0, 1, 2, 3, 0};

        for (int i = 0; i < 4; i++) a_in_data[i*64 +: 64] = chan_a(i);
        for (int i = 0; i < 3; i++) b_in_data[i*8 +: 8] = chan_b(i);
        a_reset = 1'b1; a_in_valid = '0; a_out_ready = 1'b1;
        b_reset = 1'b1; b_in_valid = '0; b_out_ready = 1'b1;

        @(negedge clk);
        step_a(4'b1111, 1'b1, 1'b1, w);
        step_a(4'b1111, 1'b1, 1'b1, w);

        for (int i = 0; i < 5; i++) begin
            step_a(4'b1111, 1'b1, 1'b0, w);
            chk("rotation", 64'(a_out_sel), 64'(rot_exp[i]));
        end

        step_a(4'b1111, 1'b1, 1'b0, w);
        step_a(4'b1111, 1'b1, 1'b0, w);
        chk("pre_skip_ch2", 64'(a_out_sel), 64'(2));
        step_a(4'b0011, 1'b1, 1'b0, w);
        chk("skip_wrap_0", 64'(a_out_sel), 64'(0));
        step_a(4'b0011, 1'b1, 1'b0, w);
        chk("skip_wrap_1", 64'(a_out_sel), 64'(1));
        step_a(4'b0011, 1'b1, 1'b0, w);
        chk("skip_wrap_2", 64'(a_out_sel), 64'(0));

        step_a(4'b1111, 1'b1, 1'b0, w);
        chk("bp_setup_sel", 64'(a_out_sel), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step_a(4'b1111, 1'b0, 1'b0, w);
            chk("bp_hold_sel", 64'(a_out_sel), 64'(1));
            chk("bp_hold_data", a_out_data, chan_a(1));
        end
        step_a(4'b1111, 1'b1, 1'b0, w);
        chk("bp_release", 64'(a_out_sel), 64'(2));

        step_a(4'b0000, 1'b1, 1'b0, w);
        chk("drain_valid", 64'(a_out_valid), 64'(0));
        chk("drain_data_held", a_out_data, chan_a(2));

        step_a(4'b1111, 1'b1, 1'b0, w);
        chk("pending_sel", 64'(a_out_sel), 64'(3));
        step_a(4'b1111, 1'b0, 1'b1, w);
        chk("midreset_valid", 64'(a_out_valid), 64'(0));
        step_a(4'b1111, 1'b1, 1'b0, w);
        chk("post_reset_ch0", 64'(a_out_sel), 64'(0));

        step_b(3'b111, 1'b1, w);
        for (int i = 0; i < 3; i++) begin
            step_b(3'b111, 1'b0, w);
            chk("fixed_111", 64'(b_out_sel), 64'(0));
        end
        for (int i = 0; i < 3; i++) begin
            step_b(3'b110, 1'b0, w);
            chk("fixed_110", 64'(b_out_sel), 64'(1));
        end
        step_b(3'b100, 1'b0, w);
        chk("fixed_100", 64'(b_out_sel), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, WIDTH-bit arbitrated multiplexer with a registered output stage. It is the successor to the fixed 64-bit 4:1 mux.
- Each channel presents data under a valid/ready handshake. One channel is granted per cycle, round-robin or fixed-priority, and the selected word is registered toward a single downstream consumer.
- Used where several producers (forwarding sources, memory response ports) share one 64-bit datapath.

Parameters:
- WIDTH, 64, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2).
- PRIO_MODE, 0, arbitration mode. 0 = round-robin; 1 = fixed priority, where the lowest valid index wins.
- SELW, $clog2(N), width of the select/grant index. Derived; never overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept. Combinational; at most one bit is high.
- out_valid  output  1  registered output holds a valid word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SELW  index of the channel that produced out_data (registered).
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sel=0. Internal last-grant pointer=N-1, so channel 0 has first priority after reset.
- Reset has priority over all other activity. If reset is asserted mid-transfer, the held word is dropped and no handshake completes that cycle.
- The output stage can load when out_valid=0 or out_ready=1.
- Grant selection when the stage can load and any in_valid bit is set:
  - PRIO_MODE=0: the winner is the first valid index searched from last+1 upward, wrapping modulo N.
  - PRIO_MODE=1: the winner is the lowest valid index; the last-grant pointer is still updated but ignored.
- Grant effects:
  - in_ready[winner]=1; all other in_ready bits are 0.
  - On the next edge: out_data<=in_data[winner], out_sel<=winner, out_valid<=1, last<=winner.
- When the stage can load and no channel is valid: all in_ready=0. On the next edge out_valid<=0; out_data, out_sel and last hold.
- Stall (out_valid=1, out_ready=0): all in_ready=0; out_valid, out_data, out_sel and last all hold.
- Data is taken from in_data only when in_ready[i] and in_valid[i] are both high in the same cycle.
- Latency: 1 cycle from accept to out_valid. Full throughput of one word per cycle is sustained while out_ready=1.
- Simultaneous drain and fill: with out_valid=1 and out_ready=1 in the same cycle as a grant, the old word is consumed and the new word is loaded on the same edge (no bubble).
- Fairness: in round-robin mode with all N channels valid continuously and out_ready=1, grants cycle 0,1,...,N-1,0,... No channel waits more than N-1 grants.
- Wrap-around: if last=N-1, the search starts at index 0.
- Non-power-of-2 N: indices >= N are never produced on out_sel.
- Sources must hold in_data stable while in_valid is high and not yet accepted. The block does not check this.
- There are no combinational paths from in_data to any output.
- The only combinational path from in_valid or out_ready is to in_ready.

Decomposition:
- Package mux_pkg:
  - localparam defaults DATA_W=64 and NCH=4.
  - typedef enum {PRIO_RR=0, PRIO_FIXED=1} prio_mode_t, used for the PRIO_MODE value.
- One sub-module, rr_pick:
  - Combinational rotating priority picker.
  - Inputs: req[N], start[SELW], fixed.
  - Outputs: any, idx[SELW].
  - Implemented as a double-width request vector searched from start.
- rr_arb_mux instantiates rr_pick and holds the output register, the last-grant pointer and the in_ready decode.

Test Plan:
- Reset test (WIDTH=64, N=4): hold reset for 2 cycles with all in_valid=1. Required: out_valid=0, out_data=0, out_sel=0, in_ready=0000 throughout. One cycle after release, out_sel=0.
- Round-robin rotation: in_valid=1111, channel i data = 64'h1111_0000_0000_0000*(i+1), out_ready=1 always. Required: out_sel sequence 0,1,2,3,0, with out_data matching each channel, one word per cycle.
- Skip and wrap: after a grant to channel 2, set in_valid=0011. Required: the next grant goes to channel 0, then channel 1, then channel 0.
- Backpressure: with out_valid=1 and out_sel=1, drive out_ready=0 for 3 cycles with in_valid=1111. Required: in_ready=0000 and out_data/out_sel stable for all 3 cycles. When out_ready returns to 1, channel 2 is granted.
- Fixed mode (PRIO_MODE=1, N=3, WIDTH=8): in_valid=111 held, out_ready=1. Required: out_sel=0 every cycle. With in_valid=110, out_sel=1 every cycle; out_sel never reads 3.
- Empty drain plus reset mid-op: with one word held and out_ready=1, drop all in_valid; out_valid must fall next cycle with out_data held. Then, with a word pending (out_valid=1, out_ready=0), assert reset for 1 cycle. Required: out_valid=0 on the next edge and the last-grant pointer reset, so channel 0 is granted first again.
